// File: rtl/arp_pkg.sv
// Shared constants, field positions and state encoding for the ARP receive path.
// Field MSBs index into the 224-bit packet register, byte 0 at the top.
package arp_pkg;

    localparam int ARP_PKT_BITS = 224;

    localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ARP_OPER_REQ   = 16'd1;
    localparam logic [15:0] ARP_OPER_REP   = 16'd2;
    localparam logic [7:0]  ARP_HLEN_ETH   = 8'd6;
    localparam logic [7:0]  ARP_PLEN_IPV4  = 8'd4;

    localparam int OFF_HTYPE = 0;
    localparam int OFF_PTYPE = 2;
    localparam int OFF_HLEN  = 4;
    localparam int OFF_PLEN  = 5;
    localparam int OFF_OPER  = 6;
    localparam int OFF_SHA   = 8;
    localparam int OFF_SPA   = 14;
    localparam int OFF_THA   = 18;
    localparam int OFF_TPA   = 24;

    localparam int MSB_HTYPE = ARP_PKT_BITS - 1 - 8 * OFF_HTYPE;
    localparam int MSB_PTYPE = ARP_PKT_BITS - 1 - 8 * OFF_PTYPE;
    localparam int MSB_HLEN  = ARP_PKT_BITS - 1 - 8 * OFF_HLEN;
    localparam int MSB_PLEN  = ARP_PKT_BITS - 1 - 8 * OFF_PLEN;
    localparam int MSB_OPER  = ARP_PKT_BITS - 1 - 8 * OFF_OPER;
    localparam int MSB_SHA   = ARP_PKT_BITS - 1 - 8 * OFF_SHA;
    localparam int MSB_SPA   = ARP_PKT_BITS - 1 - 8 * OFF_SPA;
    localparam int MSB_THA   = ARP_PKT_BITS - 1 - 8 * OFF_THA;
    localparam int MSB_TPA   = ARP_PKT_BITS - 1 - 8 * OFF_TPA;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CHECK   = 2'd1,
        EMIT    = 2'd2
    } arp_state_e;

endpackage

// File: rtl/arp_sat_counter.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
module arp_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_count <= '0;
        end else if (i_inc && (o_count != {W{1'b1}})) begin
            o_count <= o_count + 1'b1;
        end
    end

endmodule

// File: rtl/arp_rx_filter.sv
// ARP receive parser/filter: collects a 28-byte payload, validates it and
// issues independent cache-write and reply requests with valid/ready handshakes.
module arp_rx_filter
    import arp_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ACCEPT_ALL = 0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       my_ip,
    input  logic              arp_valid,
    input  logic              arp_sop,
    input  logic [DATA_W-1:0] arp_data,
    output logic              arp_ready,
    output logic              w_en,
    input  logic              w_ready,
    output logic [31:0]       w_ip_addr,
    output logic [47:0]       w_mac_addr,
    output logic              send_en,
    input  logic              send_ready,
    output logic [31:0]       send_ip_addr,
    output logic [47:0]       send_mac_addr,
    output logic [CNT_W-1:0]  pkt_ok_cnt,
    output logic [CNT_W-1:0]  pkt_drop_cnt
);

    localparam int NW    = ARP_PKT_BITS / DATA_W;
    localparam int IDX_W = $clog2(NW);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NW - 1);

    arp_state_e r_state;
    arp_state_e w_next;

    logic [ARP_PKT_BITS-1:0] r_shift;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_alive;

    logic w_xfer;
    logic w_valid_hdr;
    logic w_is_mine;
    logic w_do_write;
    logic w_do_reply;
    logic w_inc_ok;
    logic w_inc_drop;
    logic w_load;
    logic w_unused_tha;

    logic [15:0] w_htype;
    logic [15:0] w_ptype;
    logic [7:0]  w_hlen;
    logic [7:0]  w_plen;
    logic [15:0] w_oper;
    logic [47:0] w_sha;
    logic [31:0] w_spa;
    logic [31:0] w_tpa;

    assign w_htype = r_shift[MSB_HTYPE -: 16];
    assign w_ptype = r_shift[MSB_PTYPE -: 16];
    assign w_hlen  = r_shift[MSB_HLEN  -: 8];
    assign w_plen  = r_shift[MSB_PLEN  -: 8];
    assign w_oper  = r_shift[MSB_OPER  -: 16];
    assign w_sha   = r_shift[MSB_SHA   -: 48];
    assign w_spa   = r_shift[MSB_SPA   -: 32];
    assign w_tpa   = r_shift[MSB_TPA   -: 32];
    assign w_unused_tha = ^r_shift[MSB_THA -: 48];

    assign w_valid_hdr = (w_htype == ARP_HTYPE_ETH)
                      && (w_ptype == ARP_PTYPE_IPV4)
                      && (w_hlen == ARP_HLEN_ETH)
                      && (w_plen == ARP_PLEN_IPV4)
                      && ((w_oper == ARP_OPER_REQ) || (w_oper == ARP_OPER_REP));
    assign w_is_mine  = (w_tpa == my_ip);
    assign w_do_write = w_valid_hdr && ((ACCEPT_ALL != 0) || w_is_mine);
    assign w_do_reply = w_valid_hdr && (w_oper == ARP_OPER_REQ) && w_is_mine;

    // r_alive keeps arp_ready low while reset is held
    assign arp_ready = r_alive && (r_state == COLLECT);
    assign w_xfer    = arp_valid && arp_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= COLLECT;
            r_alive <= 1'b0;
        end else begin
            r_state <= w_next;
            r_alive <= 1'b1;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_inc_ok   = 1'b0;
        w_inc_drop = 1'b0;
        w_load     = 1'b0;
        unique case (r_state)
            COLLECT: begin
                if (w_xfer && arp_sop && (r_idx != '0)) begin
                    w_inc_drop = 1'b1;
                end
                if (w_xfer && !arp_sop && (r_idx == LAST)) begin
                    w_next = CHECK;
                end
            end
            CHECK: begin
                if (w_do_write || w_do_reply) begin
                    w_inc_ok = 1'b1;
                    w_load   = 1'b1;
                    w_next   = EMIT;
                end else begin
                    w_inc_drop = 1'b1;
                    w_next     = COLLECT;
                end
            end
            EMIT: begin
                if ((!w_en || w_ready) && (!send_en || send_ready)) begin
                    w_next = COLLECT;
                end
            end
            default: w_next = COLLECT;
        endcase
    end

    // sop always restarts at word 0; a stray non-sop word at index 0 is dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (w_xfer) begin
            if (arp_sop) begin
                r_shift <= {r_shift[ARP_PKT_BITS-DATA_W-1:0], arp_data};
                r_idx   <= IDX_W'(1);
            end else if (r_idx != '0) begin
                r_shift <= {r_shift[ARP_PKT_BITS-DATA_W-1:0], arp_data};
                r_idx   <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_en          <= 1'b0;
            send_en       <= 1'b0;
            w_ip_addr     <= '0;
            w_mac_addr    <= '0;
            send_ip_addr  <= '0;
            send_mac_addr <= '0;
        end else if (w_load) begin
            w_en          <= w_do_write;
            send_en       <= w_do_reply;
            w_ip_addr     <= w_spa;
            w_mac_addr    <= w_sha;
            send_ip_addr  <= w_spa;
            send_mac_addr <= w_sha;
        end else begin
            if (w_en && w_ready) begin
                w_en <= 1'b0;
            end
            if (send_en && send_ready) begin
                send_en <= 1'b0;
            end
        end
    end

    arp_sat_counter #(.W(CNT_W)) u_ok_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_inc   (w_inc_ok),
        .o_count (pkt_ok_cnt)
    );

    arp_sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_inc   (w_inc_drop),
        .o_count (pkt_drop_cnt)
    );

endmodule
